// File: rtl/cudu_pkg.sv
// Shared definitions for the cudu sequential compute engine.
package cudu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DY3  = 3'd1,
    DYZ  = 3'd2,
    DX3  = 3'd3,
    SUB  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int DIV3 = 3;

  // Edges from the accepting edge to the edge that raises done.
  function automatic int lat(input int ow);
    return 3 * ow + 4;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: first iteration on the go edge, result valid with
// div_done exactly OW cycles after go.
module seq_divider #(
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [OW-1:0] dividend,
  input  logic [OW-1:0] divisor,
  output logic [OW-1:0] quotient,
  output logic          div_done,
  output logic          busy
);
  localparam int CW = $clog2(OW + 1);

  logic [OW-1:0] rem, q, dvs;
  logic [CW-1:0] cnt;
  logic          run;

  // One restoring step: shift in the next dividend bit, trial subtract.
  function automatic logic [2*OW-1:0] step(input logic [OW-1:0] r,
                                           input logic [OW-1:0] qq,
                                           input logic [OW-1:0] d);
    logic [OW:0] tr;
    tr = {r, qq[OW-1]} - {1'b0, d};
    if (!tr[OW]) return {tr[OW-1:0], qq[OW-2:0], 1'b1};
    else         return {r[OW-2:0], qq[OW-1], qq[OW-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      q   <= '0;
      dvs <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (go) begin
      {rem, q} <= step('0, dividend, divisor);
      dvs      <= divisor;
      cnt      <= CW'(1);
      run      <= 1'b1;
    end else if (run) begin
      if (cnt == CW'(OW)) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        {rem, q} <= step(rem, q, dvs);
        cnt      <= cnt + CW'(1);
      end
    end
  end

  assign quotient = q;
  assign div_done = run && (cnt == CW'(OW));
  assign busy     = run;

endmodule

// File: rtl/cudu_seq.sv
// Control FSM and datapath computing x = (2*xin)/3 - (yin/3)/(xin*xin)
// through one shared sequential divider.
module cudu_seq
  import cudu_pkg::*;
#(
  parameter int W   = 4,
  parameter int OW  = 2 * W,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  xin,
  input  logic [W-1:0]  yin,
  output logic          idle,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] x,
  output logic          div0,
  output logic          uflow
);
  localparam int CW = $clog2(OW + 1);

  state_t        state;
  logic [OW-1:0] xr, yr, zr, tr;
  logic [CW-1:0] cnt;
  logic          div0_r;
  logic          zero_z;

  logic          go, div_done, div_busy;
  logic [OW-1:0] dvd, dvs, quo;

  assign zero_z = (zr == '0);

  // Issue on the first cycle of a divide state; a zero z skips the
  // divider but DYZ still waits the same OW+1 cycles.
  always_comb begin
    dvd = yr;
    dvs = OW'(DIV3);
    go  = 1'b0;
    case (state)
      DY3: begin dvd = yr;      dvs = OW'(DIV3); go = (cnt == '0); end
      DYZ: begin dvd = yr;      dvs = zr;        go = (cnt == '0) && !zero_z; end
      DX3: begin dvd = xr << 1; dvs = OW'(DIV3); go = (cnt == '0); end
      default: ;
    endcase
    go = go && !div_busy;
  end

  seq_divider #(.OW(OW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .dividend (dvd),
    .divisor  (dvs),
    .quotient (quo),
    .div_done (div_done),
    .busy     (div_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      tr     <= '0;
      cnt    <= '0;
      div0_r <= 1'b0;
      x      <= '0;
      div0   <= 1'b0;
      uflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr     <= OW'(xin);
          yr     <= OW'(yin);
          zr     <= OW'(xin) * OW'(xin);
          div0_r <= 1'b0;
          cnt    <= '0;
          state  <= DY3;
        end
        DY3: begin
          cnt <= cnt + CW'(1);
          if (div_done) begin
            yr    <= quo;
            cnt   <= '0;
            state <= DYZ;
          end
        end
        DYZ: begin
          cnt <= cnt + CW'(1);
          if (zero_z ? (cnt == CW'(OW)) : div_done) begin
            yr     <= zero_z ? '0 : quo;
            div0_r <= zero_z;
            cnt    <= '0;
            state  <= DX3;
          end
        end
        DX3: begin
          cnt <= cnt + CW'(1);
          if (div_done) begin
            tr    <= quo;
            cnt   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          div0  <= div0_r;
          uflow <= (tr < yr);
          if (tr < yr && SAT != 0) x <= '0;
          else                     x <= tr - yr;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign idle = (state == IDLE);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cudu_seq.sv
// Randomized bench for cudu_seq (wrapping and saturating builds side by side)
// against an arithmetic reference model.
module tb_cudu_seq;
  import cudu_pkg::*;

  localparam int W  = 4;
  localparam int OW = 2 * W;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] xin = '0, yin = '0;
  logic idle, busy, done, div0, uflow;
  logic idle_s, busy_s, done_s, div0_s, uflow_s;
  logic [OW-1:0] x, x_s;

  int checks = 0, errors = 0;
  int prev_x = 0, prev_xs = 0;

  always #5 clk = ~clk;

  cudu_seq #(.W(W), .OW(OW), .SAT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .xin(xin), .yin(yin),
    .idle(idle), .busy(busy), .done(done), .x(x), .div0(div0), .uflow(uflow)
  );

  cudu_seq #(.W(W), .OW(OW), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .xin(xin), .yin(yin),
    .idle(idle_s), .busy(busy_s), .done(done_s), .x(x_s), .div0(div0_s),
    .uflow(uflow_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the formulas with integer floor division.
  task automatic model(input int xv, input int yv, input int sat,
                       output int rx, output int rd0, output int ruf);
    int z, y1, y2, t;
    z  = xv * xv;
    y1 = yv / 3;
    rd0 = (z == 0);
    y2 = rd0 ? 0 : y1 / z;
    t  = (2 * xv) / 3;
    ruf = (t < y2);
    if (!ruf)     rx = t - y2;
    else if (sat) rx = 0;
    else          rx = (t - y2 + (1 << OW)) % (1 << OW);
  endtask

  // Issue one op from IDLE; noisy toggles start/operands while busy.
  task automatic do_op(input int xv, input int yv, input bit noisy);
    int ex, ed, eu, exs, eds, eus, n, nb;
    model(xv, yv, 0, ex, ed, eu);
    model(xv, yv, 1, exs, eds, eus);
    @(negedge clk);
    chk("idle_pre", idle, 1);
    chk("done_pre", done, 0);
    start = 1'b1; xin = W'(xv); yin = W'(yv);
    @(posedge clk);
    n = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (noisy) begin
        start = 1'($urandom); xin = W'($urandom); yin = W'($urandom);
      end else start = 1'b0;
      n++;
      if (n == 1) begin
        chk("x_hold", x, prev_x);
        chk("xs_hold", x_s, prev_xs);
      end
      if (busy) nb++;
      if (done || n > 100) break;
    end
    start = 1'b0;
    chk("latency", n - 1, lat(OW));
    chk("busy_cycles", nb, lat(OW) + 1);
    chk("done_sat_align", done_s, 1);
    chk("x", x, ex);
    chk("div0", div0, ed);
    chk("uflow", uflow, eu);
    chk("x_sat", x_s, exs);
    chk("div0_sat", div0_s, eds);
    chk("uflow_sat", uflow_s, eus);
    prev_x = ex; prev_xs = exs;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_div0"}, div0, 0);
    chk({tag, "_uflow"}, uflow, 0);
    chk({tag, "_xs"}, x_s, 0);
  endtask

  initial begin
    int seen;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    do_op(2, 15, 0);
    do_op(3, 9, 0);
    do_op(6, 15, 0);
    do_op(1, 15, 0);
    do_op(0, 12, 0);
    do_op(15, 15, 1);
    for (int i = 0; i < 20; i++)
      do_op($urandom_range(0, 15), $urandom_range(0, 15), i[0]);

    // Abort in DYZ (cycles OW+2..2*OW+2 after accept) with nonzero x held.
    do_op(1, 15, 0);
    @(negedge clk);
    start = 1'b1; xin = 4'd1; yin = 4'd15;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (OW + 3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("abort");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    rst = 1'b0;
    prev_x = 0; prev_xs = 0;
    do_op(2, 15, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
